// File: rtl/sm3_cmprss_ceil.sv
// sm3_cmprss_ceil -- one SM3 compression round.
//   Takes word registers A..H with Wj, Wj' and the pre-rotated constant Tj,
//   and produces the next-round A..H. Two instances chained give 2 rounds/clock.
//
// Build option:
//   SM3_CEIL_OTPT_REG_EN defined   : outputs registered, latency 1, sync reset.
//   SM3_CEIL_OTPT_REG_EN undefined : purely combinational, vld_o = vld_i,
//                                    clk/rst unused (kept for uniform hookup).
//
// Ports:
//   clk, rst                  clock (rising edge), synchronous active-high reset
//   vld_i                     round inputs valid
//   cmprss_round_sm_16_i      1: round j<16 (XOR FF/GG), 0: majority/choose
//   tj_i                      Tj <<< (j mod 32), supplied by caller
//   reg_a_i .. reg_h_i        current A..H
//   wj_i, wjj_i               Wj and Wj' = Wj ^ Wj+4
//   reg_a_o .. reg_h_o        next-round A..H
//   vld_o                     reg_*_o valid
module sm3_cmprss_ceil (
  input  logic        clk,
  input  logic        rst,
  input  logic        vld_i,
  input  logic        cmprss_round_sm_16_i,
  input  logic [31:0] tj_i,
  input  logic [31:0] reg_a_i,
  input  logic [31:0] reg_b_i,
  input  logic [31:0] reg_c_i,
  input  logic [31:0] reg_d_i,
  input  logic [31:0] reg_e_i,
  input  logic [31:0] reg_f_i,
  input  logic [31:0] reg_g_i,
  input  logic [31:0] reg_h_i,
  input  logic [31:0] wj_i,
  input  logic [31:0] wjj_i,
  output logic [31:0] reg_a_o,
  output logic [31:0] reg_b_o,
  output logic [31:0] reg_c_o,
  output logic [31:0] reg_d_o,
  output logic [31:0] reg_e_o,
  output logic [31:0] reg_f_o,
  output logic [31:0] reg_g_o,
  output logic [31:0] reg_h_o,
  output logic        vld_o
);

  typedef struct packed {
    logic [31:0] a, b, c, d, e, f, g, h;
  } sm3_words_t;

  function automatic logic [31:0] rol(input logic [31:0] x, input int unsigned n);
    return (x << n) | (x >> (32 - n));
  endfunction

  sm3_words_t  nxt;
  logic [31:0] a12, ss1, ss2, ff, gg, tt1, tt2;

  always_comb begin
    a12 = rol(reg_a_i, 12);
    ss1 = rol(a12 + reg_e_i + tj_i, 7);
    ss2 = ss1 ^ a12;
    ff  = cmprss_round_sm_16_i ? (reg_a_i ^ reg_b_i ^ reg_c_i)
                               : ((reg_a_i & reg_b_i) | (reg_a_i & reg_c_i) | (reg_b_i & reg_c_i));
    gg  = cmprss_round_sm_16_i ? (reg_e_i ^ reg_f_i ^ reg_g_i)
                               : ((reg_e_i & reg_f_i) | (~reg_e_i & reg_g_i));
    tt1 = ff + reg_d_i + ss2 + wjj_i;
    tt2 = gg + reg_h_i + ss1 + wj_i;
    nxt.a = tt1;
    nxt.b = reg_a_i;
    nxt.c = rol(reg_b_i, 9);
    nxt.d = reg_c_i;
    nxt.e = tt2 ^ rol(tt2, 9) ^ rol(tt2, 17);  // P0
    nxt.f = reg_e_i;
    nxt.g = rol(reg_f_i, 19);
    nxt.h = reg_g_i;
  end

  sm3_words_t q;

`ifdef SM3_CEIL_OTPT_REG_EN
  // Words load only on vld_i so junk on idle inputs never reaches the outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      q     <= '0;
      vld_o <= 1'b0;
    end else begin
      vld_o <= vld_i;
      if (vld_i) q <= nxt;
    end
  end
`else
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst;
  assign q     = nxt;
  assign vld_o = vld_i;
`endif

  assign reg_a_o = q.a;
  assign reg_b_o = q.b;
  assign reg_c_o = q.c;
  assign reg_d_o = q.d;
  assign reg_e_o = q.e;
  assign reg_f_o = q.f;
  assign reg_g_o = q.g;
  assign reg_h_o = q.h;

endmodule

// File: tb/tb_sm3_cmprss_ceil.sv
// Self-checking bench for sm3_cmprss_ceil; follows whichever build mode
// SM3_CEIL_OTPT_REG_EN selects. Directed literal cases plus randomized
// traffic checked every cycle against a word-level reference model.
module tb_sm3_cmprss_ceil;

  typedef logic [31:0] w8_t [8];

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vld = 1'b0;
  logic        sm16 = 1'b0;
  logic [31:0] tj = '0, wj = '0, wjj = '0;
  w8_t         in_w;
  w8_t         out_w;
  logic        vld_o;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  sm3_cmprss_ceil dut (
    .clk(clk), .rst(rst), .vld_i(vld), .cmprss_round_sm_16_i(sm16), .tj_i(tj),
    .reg_a_i(in_w[0]), .reg_b_i(in_w[1]), .reg_c_i(in_w[2]), .reg_d_i(in_w[3]),
    .reg_e_i(in_w[4]), .reg_f_i(in_w[5]), .reg_g_i(in_w[6]), .reg_h_i(in_w[7]),
    .wj_i(wj), .wjj_i(wjj),
    .reg_a_o(out_w[0]), .reg_b_o(out_w[1]), .reg_c_o(out_w[2]), .reg_d_o(out_w[3]),
    .reg_e_o(out_w[4]), .reg_f_o(out_w[5]), .reg_g_o(out_w[6]), .reg_h_o(out_w[7]),
    .vld_o(vld_o)
  );

  // ---------------- reference model ----------------
  function automatic logic [31:0] rl(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x};
    return d[63-n -: 32];
  endfunction

  function automatic w8_t ref_round(input w8_t r, input logic [31:0] w, ww, t, input logic s16);
    w8_t         o;
    logic [31:0] a12, ss1, ss2, ff, gg, tt1, tt2;
    a12 = rl(r[0], 12);
    ss1 = rl(32'(longint'(a12) + longint'(r[4]) + longint'(t)), 7);
    ss2 = ss1 ^ a12;
    for (int i = 0; i < 32; i++) begin
      if (s16) begin
        ff[i] = r[0][i] ^ r[1][i] ^ r[2][i];
        gg[i] = r[4][i] ^ r[5][i] ^ r[6][i];
      end else begin
        ff[i] = (int'(r[0][i]) + int'(r[1][i]) + int'(r[2][i])) >= 2;
        gg[i] = r[4][i] ? r[5][i] : r[6][i];
      end
    end
    tt1 = 32'(longint'(ff) + longint'(r[3]) + longint'(ss2) + longint'(ww));
    tt2 = 32'(longint'(gg) + longint'(r[7]) + longint'(ss1) + longint'(w));
    o[0] = tt1;        o[1] = r[0]; o[2] = rl(r[1], 9);  o[3] = r[2];
    o[4] = tt2 ^ rl(tt2, 9) ^ rl(tt2, 17);
    o[5] = r[4];       o[6] = rl(r[5], 19); o[7] = r[6];
    return o;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- per-cycle compare ----------------
`ifdef SM3_CEIL_OTPT_REG_EN
  w8_t  m_w;
  logic m_vld;
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) m_w[i] = '0;
      m_vld  = 1'b0;
      chk_en = 1'b1;
    end else if (vld) begin
      m_w   = ref_round(in_w, wj, wjj, tj, sm16);
      m_vld = 1'b1;
    end else begin
      m_vld = 1'b0;
    end
  end
  always @(negedge clk) if (chk_en) begin
    chk("cyc_vld", {31'd0, vld_o}, {31'd0, m_vld});
    for (int i = 0; i < 8; i++) chk($sformatf("cyc_w%0d", i), out_w[i], m_w[i]);
  end
`else
  always @(negedge clk) begin
    w8_t e;
    chk("cyc_vld", {31'd0, vld_o}, {31'd0, vld});
    if (vld) begin
      e = ref_round(in_w, wj, wjj, tj, sm16);
      for (int i = 0; i < 8; i++) chk($sformatf("cyc_w%0d", i), out_w[i], e[i]);
    end
  end
`endif

  // ---------------- directed helpers ----------------
  task automatic apply(input w8_t r, input logic [31:0] w, ww, t, input logic s16, input logic v);
    @(posedge clk); #2;
    in_w = r; wj = w; wjj = ww; tj = t; sm16 = s16; vld = v;
  endtask

  task automatic expect_out(input string nm, input w8_t e, input logic ev);
`ifdef SM3_CEIL_OTPT_REG_EN
    @(posedge clk);
`endif
    @(negedge clk);
    chk({nm, "_vld"}, {31'd0, vld_o}, {31'd0, ev});
    for (int i = 0; i < 8; i++) chk($sformatf("%s_w%0d", nm, i), out_w[i], e[i]);
  endtask

  w8_t zero8, iv, abc_exp, ones_a, e3, e4, rnd, pin;

  initial begin
    for (int i = 0; i < 8; i++) begin zero8[i] = '0; in_w[i] = '0; end
    iv      = '{32'h7380166f, 32'h4914b2b9, 32'h172442d7, 32'hda8a0600,
                32'ha96f30bc, 32'h163138aa, 32'he38dee4d, 32'hb0fb0e4e};
    abc_exp = '{32'hb9edc12b, 32'h7380166f, 32'h29657292, 32'h172442d7,
                32'hb2ad29f4, 32'ha96f30bc, 32'hc550b189, 32'he38dee4d};
    ones_a  = zero8; ones_a[0] = 32'hffffffff;
    e3 = zero8; e3[0] = 32'hffffffff; e3[1] = 32'hffffffff; e3[4] = 32'hffffffff;
    e4 = zero8; e4[1] = 32'hffffffff; e4[4] = 32'hffffffff;

    // Pin the model itself against the published "abc" round-0 values.
    pin = ref_round(iv, 32'h61626380, 32'h61626380, 32'h79cc4519, 1'b1);
    for (int i = 0; i < 8; i++) chk($sformatf("model_abc_w%0d", i), pin[i], abc_exp[i]);

    // 1: reset, then idle after reset holds zero
    @(posedge clk); #2;
    expect_out("reset", zero8, 1'b0);
    @(posedge clk); #2; rst = 1'b0;
    expect_out("idle_hold", zero8, 1'b0);

    // 2: SM3 "abc" round 0
    apply(iv, 32'h61626380, 32'h61626380, 32'h79cc4519, 1'b1, 1'b1);
    expect_out("abc_r0", abc_exp, 1'b1);
    // 3 / 4: XOR path vs majority path with A all-ones
    apply(ones_a, 0, 0, 0, 1'b1, 1'b1);
    expect_out("xor_ones", e3, 1'b1);
    apply(ones_a, 0, 0, 0, 1'b0, 1'b1);
    expect_out("maj_ones", e4, 1'b1);
    // 5: all zero, then idle with random junk
    apply(zero8, 0, 0, 0, 1'b0, 1'b1);
    expect_out("all_zero", zero8, 1'b1);
    for (int i = 0; i < 8; i++) rnd[i] = $urandom;
    apply(rnd, $urandom, $urandom, $urandom, 1'b1, 1'b0);
`ifdef SM3_CEIL_OTPT_REG_EN
    expect_out("idle_junk", zero8, 1'b0);
`else
    @(negedge clk);
    chk("idle_junk_vld", {31'd0, vld_o}, 32'd0);
`endif

    // Randomized traffic incl. back-to-back rounds and mid-stream resets.
    for (int n = 0; n < 400; n++) begin
      @(posedge clk); #2;
      for (int i = 0; i < 8; i++) in_w[i] = $urandom;
      wj = $urandom; wjj = $urandom; tj = $urandom;
      sm16 = 1'($urandom_range(0, 1));
      vld  = ($urandom_range(0, 3) != 0);
      rst  = ($urandom_range(0, 49) == 0);
    end
    @(posedge clk); #2; rst = 1'b0; vld = 1'b0;
    @(posedge clk); @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
